// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe input path: button FSM
// states, board geometry and the per-button next-state helper.
package game_pkg;

  localparam int unsigned NUM_POS = 9;

  // Board bit index: bit 8 = top-left ... bit 0 = bottom-right
  localparam int unsigned POS_TL = 8;
  localparam int unsigned POS_TM = 7;
  localparam int unsigned POS_TR = 6;
  localparam int unsigned POS_ML = 5;
  localparam int unsigned POS_MM = 4;
  localparam int unsigned POS_MR = 3;
  localparam int unsigned POS_BL = 2;
  localparam int unsigned POS_BM = 1;
  localparam int unsigned POS_BR = 0;

  typedef enum logic [1:0] {
    BTN_RELEASED     = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_HELD         = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_t;

  typedef struct packed {
    btn_state_t state;
    logic       pulse;
  } btn_step_t;

  // Next state and strobe for one button, given its synchronised level and
  // the debouncer's commit flag for this cycle.
  function automatic btn_step_t btn_step(input btn_state_t cur,
                                         input logic       synced,
                                         input logic       commit);
    btn_step_t r;
    r.state = cur;
    r.pulse = 1'b0;
    unique case (cur)
      BTN_RELEASED: begin
        if (synced) begin
          // A single-cycle debounce window can commit on the first sample
          if (commit) begin
            r.state = BTN_HELD;
            r.pulse = 1'b1;
          end else begin
            r.state = BTN_PRESS_WAIT;
          end
        end
      end
      BTN_PRESS_WAIT: begin
        if (commit) begin
          r.state = BTN_HELD;
          r.pulse = 1'b1;
        end else if (!synced) begin
          r.state = BTN_RELEASED;
        end
      end
      BTN_HELD: begin
        if (!synced) begin
          r.state = commit ? BTN_RELEASED : BTN_RELEASE_WAIT;
        end
      end
      BTN_RELEASE_WAIT: begin
        if (commit) begin
          r.state = BTN_RELEASED;
        end else if (synced) begin
          r.state = BTN_HELD;
        end
      end
    endcase
    return r;
  endfunction

  // Button is (or may be about to be) down from the game's point of view
  function automatic logic btn_engaged(input btn_state_t s);
    return (s == BTN_PRESS_WAIT) || (s == BTN_HELD);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input: SYNC_STAGES-flop synchroniser followed by a consecutive-sample
// debouncer holding the committed level.
module debounce_cell
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_synced,
  output logic o_level,
  output logic o_commit_c
);

  localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   w_diff;

  // Plain flop chain, nothing between stages
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign o_synced   = r_sync[SYNC_STAGES-1];
  assign w_diff     = o_synced != r_level;
  assign o_commit_c = w_diff && (r_cnt == CNT_LAST);

  // Any sample matching the committed level restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (o_commit_c) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/game_input_cond.sv
// Conditions the raw player buttons and position switches for the game FSM:
// one strobe per debounced press and clean switch levels.
// Build option GAME_INPUT_SEL_LOCK_EN freezes sel_pos while a button is down.
module game_input_cond
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned NUM_POS         = game_pkg::NUM_POS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_x_raw,
  input  logic               btn_o_raw,
  input  logic [NUM_POS-1:0] sw_raw,
  output logic               button_x_pulse,
  output logic               button_o_pulse,
  output logic               both_pulse,
  output logic [NUM_POS-1:0] sel_pos,
  output logic               sel_changing
);

  logic [1:0]         w_btn_sync;
  logic [1:0]         w_btn_level;
  logic [1:0]         w_btn_commit;
  logic [NUM_POS-1:0] w_sw_sync;
  logic [NUM_POS-1:0] w_sw_level;
  logic [NUM_POS-1:0] w_sw_commit;

  btn_state_t r_state_x;
  btn_state_t r_state_o;
  btn_step_t  w_step_x;
  btn_step_t  w_step_o;
  logic       r_pulse_x;
  logic       r_pulse_o;
  logic       r_pulse_both;

  // Buttons come out of reset assumed held, so a held button cannot strobe
  debounce_cell #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_db_x (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (btn_x_raw),
    .o_synced  (w_btn_sync[0]),
    .o_level   (w_btn_level[0]),
    .o_commit_c(w_btn_commit[0])
  );

  debounce_cell #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (1'b1)
  ) u_db_o (
    .clk       (clk),
    .reset     (reset),
    .i_raw     (btn_o_raw),
    .o_synced  (w_btn_sync[1]),
    .o_level   (w_btn_level[1]),
    .o_commit_c(w_btn_commit[1])
  );

  for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (1'b0)
    ) u_db_sw (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (sw_raw[gi]),
      .o_synced  (w_sw_sync[gi]),
      .o_level   (w_sw_level[gi]),
      .o_commit_c(w_sw_commit[gi])
    );
  end

  // Button FSM state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_x <= BTN_HELD;
      r_state_o <= BTN_HELD;
    end else begin
      r_state_x <= w_step_x.state;
      r_state_o <= w_step_o.state;
    end
  end

  // Button FSM next state and strobe request
  always_comb begin
    w_step_x = '{state: r_state_x, pulse: 1'b0};
    w_step_o = '{state: r_state_o, pulse: 1'b0};
    w_step_x = btn_step(r_state_x, w_btn_sync[0], w_btn_commit[0]);
    w_step_o = btn_step(r_state_o, w_btn_sync[1], w_btn_commit[1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pulse_x    <= 1'b0;
      r_pulse_o    <= 1'b0;
      r_pulse_both <= 1'b0;
    end else begin
      r_pulse_x    <= w_step_x.pulse;
      r_pulse_o    <= w_step_o.pulse;
      r_pulse_both <= w_step_x.pulse & w_step_o.pulse;
    end
  end

  assign button_x_pulse = r_pulse_x;
  assign button_o_pulse = r_pulse_o;
  assign both_pulse     = r_pulse_both;
  assign sel_changing   = |(w_sw_sync ^ w_sw_level);

`ifdef GAME_INPUT_SEL_LOCK_EN
  logic               w_sel_lock;
  logic [NUM_POS-1:0] r_sel_hold;

  assign w_sel_lock = btn_engaged(r_state_x) | btn_engaged(r_state_o);

  // Last value shown to the game; replayed while a button is engaged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_hold <= '0;
    end else begin
      r_sel_hold <= sel_pos;
    end
  end

  assign sel_pos = w_sel_lock ? r_sel_hold : w_sw_level;
`else
  assign sel_pos = w_sw_level;
`endif

  // Button levels are tracked by the FSM; kept visible for debug probes
  logic w_unused;
  assign w_unused = ^{w_btn_level, w_sw_commit};

endmodule

// File: tb/tb_game_input_cond.sv
// Bench for game_input_cond: directed test-plan steps followed by random
// traffic, every cycle compared against a sample-window reference model.
module tb_game_input_cond;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned NP   = 9;
  localparam int unsigned NIN  = NP + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_x_raw;
  logic          btn_o_raw;
  logic [NP-1:0] sw_raw;
  logic          button_x_pulse;
  logic          button_o_pulse;
  logic          both_pulse;
  logic [NP-1:0] sel_pos;
  logic          sel_changing;

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;

  // Reference model: raw delayed SYNC samples; a level flips once the last
  // DEB delayed samples all disagree with it. Index 0 = X, 1 = O, 2+i = sw[i].
  bit            m_sync[NIN][SYNC];
  bit            m_win[NIN][DEB];
  int            m_nv[NIN];
  bit            m_lvl[NIN];
  bit            m_eng[2];
  bit            m_px, m_po;
  logic [NP-1:0] m_sel;

  int cnt_px, cnt_po, cnt_both, cnt_chg;
  int last_px, last_po, last_both, first_sel;
  int n0;

  game_input_cond #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC),
    .NUM_POS        (NP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_x_raw     (btn_x_raw),
    .btn_o_raw     (btn_o_raw),
    .sw_raw        (sw_raw),
    .button_x_pulse(button_x_pulse),
    .button_o_pulse(button_o_pulse),
    .both_pulse    (both_pulse),
    .sel_pos       (sel_pos),
    .sel_changing  (sel_changing)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NIN; i++) begin
      for (int k = 0; k < SYNC; k++) m_sync[i][k] = 1'b0;
      for (int k = 0; k < DEB; k++)  m_win[i][k] = 1'b0;
      m_nv[i]  = 0;
      m_lvl[i] = (i < 2);
    end
    m_eng[0] = 1'b1;
    m_eng[1] = 1'b1;
    m_px     = 1'b0;
    m_po     = 1'b0;
    m_sel    = '0;
  endtask

  task automatic model_edge();
    bit rv[NIN];
    bit sp, commit;
    logic [NP-1:0] lvl_sw;
    rv[0] = btn_x_raw;
    rv[1] = btn_o_raw;
    for (int i = 0; i < NP; i++) rv[i+2] = sw_raw[i];
    m_px = 1'b0;
    m_po = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      sp = m_sync[i][SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_sync[i][k] = m_sync[i][k-1];
      m_sync[i][0] = rv[i];
      for (int k = DEB - 1; k > 0; k--) m_win[i][k] = m_win[i][k-1];
      m_win[i][0] = sp;
      if (m_nv[i] < DEB) m_nv[i]++;
      commit = (m_nv[i] >= DEB);
      for (int k = 0; k < DEB; k++) if (m_win[i][k] == m_lvl[i]) commit = 1'b0;
      if (commit) begin
        m_lvl[i] = ~m_lvl[i];
        if (i == 0 && m_lvl[i]) m_px = 1'b1;
        if (i == 1 && m_lvl[i]) m_po = 1'b1;
      end
      if (i < 2) m_eng[i] = sp;
    end
    for (int i = 0; i < NP; i++) lvl_sw[i] = m_lvl[i+2];
`ifdef GAME_INPUT_SEL_LOCK_EN
    if (!(m_eng[0] || m_eng[1])) m_sel = lvl_sw;
`else
    m_sel = lvl_sw;
`endif
  endtask

  task automatic check_all();
    bit exp_chg;
    exp_chg = 1'b0;
    for (int i = 0; i < NP; i++) if (m_sync[i+2][SYNC-1] != m_lvl[i+2]) exp_chg = 1'b1;
    chk("x_pulse", 32'(button_x_pulse), 32'(m_px));
    chk("o_pulse", 32'(button_o_pulse), 32'(m_po));
    chk("both_pulse", 32'(both_pulse), 32'(m_px & m_po));
    chk("sel_pos", 32'(sel_pos), 32'(m_sel));
    chk("sel_changing", 32'(sel_changing), 32'(exp_chg));
    if (button_x_pulse) begin cnt_px++; last_px = edge_n; end
    if (button_o_pulse) begin cnt_po++; last_po = edge_n; end
    if (both_pulse) begin cnt_both++; last_both = edge_n; end
    if (sel_changing) cnt_chg++;
    if (sel_pos[4] && first_sel < 0) first_sel = edge_n;
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      if (!reset) model_edge();
      @(posedge clk);
      edge_n++;
      #1;
      check_all();
    end
  endtask

  task automatic clear_counts();
    cnt_px = 0; cnt_po = 0; cnt_both = 0; cnt_chg = 0;
    last_px = -1; last_po = -1; last_both = -1; first_sel = -1;
  endtask

  initial begin
    reset     = 1'b1;
    btn_x_raw = 1'b1;
    btn_o_raw = 1'b0;
    sw_raw    = '0;
    model_reset();
    clear_counts();
    #2;
    check_all();
    chk("reset_sel_pos", 32'(sel_pos), 32'h0);
    step(3);
    reset = 1'b0;

    // X held through reset release: silent until released and pressed again
    clear_counts();
    step(20);
    chk("hold_no_pulse", 32'(cnt_px), 32'd0);
    btn_x_raw = 1'b0;
    step(10);
    clear_counts();
    btn_x_raw = 1'b1;
    n0 = edge_n;
    step(12);
    chk("repress_count", 32'(cnt_px), 32'd1);
    chk("repress_latency", 32'(last_px), 32'(n0 + 6));

    // Short O press is rejected
    btn_x_raw = 1'b0;
    step(10);
    clear_counts();
    btn_o_raw = 1'b1;
    step(3);
    btn_o_raw = 1'b0;
    step(12);
    chk("short_o_count", 32'(cnt_po), 32'd0);

    // Bouncing X press: single strobe after the final rise
    clear_counts();
    btn_x_raw = 1'b1; step(1);
    btn_x_raw = 1'b0; step(1);
    btn_x_raw = 1'b1; step(1);
    btn_x_raw = 1'b0; step(1);
    btn_x_raw = 1'b1;
    n0 = edge_n;
    step(10);
    chk("bounce_count", 32'(cnt_px), 32'd1);
    chk("bounce_latency", 32'(last_px), 32'(n0 + 6));

    // Simultaneous presses
    btn_x_raw = 1'b0;
    step(10);
    clear_counts();
    btn_x_raw = 1'b1;
    btn_o_raw = 1'b1;
    n0 = edge_n;
    step(10);
    chk("both_count", 32'(cnt_both), 32'd1);
    chk("both_latency", 32'(last_both), 32'(n0 + 6));
    chk("both_x_count", 32'(cnt_px), 32'd1);
    chk("both_o_count", 32'(cnt_po), 32'd1);

    // Switch change 0 -> 0x010
    btn_x_raw = 1'b0;
    btn_o_raw = 1'b0;
    step(10);
    clear_counts();
    sw_raw = 9'h010;
    n0 = edge_n;
    step(10);
    chk("sw_changing_cycles", 32'(cnt_chg), 32'd4);
    chk("sw_sel_latency", 32'(first_sel), 32'(n0 + 6));
    btn_x_raw = 1'b1;
    step(10);
    sw_raw = 9'h001;
    step(10);
`ifdef GAME_INPUT_SEL_LOCK_EN
    chk("sel_locked", 32'(sel_pos), 32'h010);
`else
    chk("sel_unlocked", 32'(sel_pos), 32'h001);
`endif
    btn_x_raw = 1'b0;
    step(10);
    chk("sel_after_release", 32'(sel_pos), 32'h001);

    // Reset mid PRESS_WAIT with the count at 2
    clear_counts();
    btn_x_raw = 1'b1;
    step(4);
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    chk("rst_x_pulse", 32'(button_x_pulse), 32'd0);
    chk("rst_sel_pos", 32'(sel_pos), 32'h0);
    chk("rst_sel_changing", 32'(sel_changing), 32'd0);
    step(2);
    reset = 1'b0;
    step(15);
    chk("rst_no_pulse", 32'(cnt_px), 32'd0);
    btn_x_raw = 1'b0;
    step(10);
    btn_x_raw = 1'b1;
    step(10);
    chk("rst_repress_count", 32'(cnt_px), 32'd1);

    // Random traffic with occasional glitches and resets
    for (int r = 0; r < 3000; r++) begin
      if ($urandom_range(0, 7) == 0) btn_x_raw = ~btn_x_raw;
      if ($urandom_range(0, 7) == 0) btn_o_raw = ~btn_o_raw;
      for (int b = 0; b < NP; b++) if ($urandom_range(0, 15) == 0) sw_raw[b] = ~sw_raw[b];
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        step(2);
        reset = 1'b0;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
